// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counter sequencer and its counter datapath:
//   - WIDTH_DEF : default counter / base / limit width
//   - OP_*      : command opcodes carried on cmd_op
//   - state_e   : sequencer state encoding (also exported on dbg_state)
//   - mode_e    : what the sequencer does after LOAD and at terminal count
package counter_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] OP_STOP    = 2'b00;
    localparam logic [1:0] OP_ONESHOT = 2'b01;
    localparam logic [1:0] OP_RELOAD  = 2'b10;
    localparam logic [1:0] OP_LOAD    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // MODE_NONE marks a LOAD_ONLY sequence: LOAD returns to IDLE.
    typedef enum logic [1:0] {
        MODE_NONE    = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_RELOAD  = 2'd2
    } mode_e;

endpackage

// File: rtl/loadable_counter.sv
// loadable_counter
//   WIDTH-bit up-counter with synchronous load and count enable.
//   Load has priority over enable; increment wraps modulo 2^WIDTH.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_ni  : asynchronous active-low reset (count -> 0)
//     load_i  : load base_i on the next rising edge
//     base_i  : value to load
//     en_i    : increment on the next rising edge (ignored while load_i)
//     count_o : current count
module loadable_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = base_i;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Command-driven controller around an internal loadable counter.
//   Commands (STOP / START_ONESHOT / START_RELOAD / LOAD_ONLY) arrive on a
//   valid/ready handshake; the counter is loaded with the captured base,
//   advanced on tick strobes in RUN, and a one-cycle done pulse is raised
//   when a tick arrives with count == limit.
//
//   Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is a pure decode of the state
//   register (low only in LOAD), so it never depends on cmd_valid.
//
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     cmd_valid/cmd_ready : command handshake
//     cmd_op              : opcode (see counter_pkg OP_*)
//     cmd_base, cmd_limit : start and terminal values, captured on accept
//     tick                : count strobe, only meaningful in RUN
//     count               : counter value
//     busy                : high in LOAD or RUN
//     done                : registered one-cycle terminal-count pulse
//     dbg_state           : current sequencer state (state_e encoding)
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_base,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    state_e           state_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] limit_q;
    logic             done_q;

    logic             accept;
    logic             at_limit;
    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_value;

    assign accept   = cmd_valid && cmd_ready;
    assign at_limit = (cnt_value == limit_q);

    // Counter control. Any accepted command in RUN takes precedence over
    // the tick, so a colliding terminal tick neither increments nor reloads.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_LOAD: cnt_load = 1'b1;
            ST_RUN: begin
                if (!accept && tick) begin
                    if (!at_limit) begin
                        cnt_en = 1'b1;
                    end else if (mode_q == MODE_RELOAD) begin
                        cnt_load = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NONE;
            base_q  <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && cmd_op != OP_STOP) begin
                        state_q <= ST_LOAD;
                        base_q  <= cmd_base;
                        limit_q <= cmd_limit;
                        mode_q  <= (cmd_op == OP_ONESHOT) ? MODE_ONESHOT :
                                   (cmd_op == OP_RELOAD)  ? MODE_RELOAD  :
                                                            MODE_NONE;
                    end
                end
                ST_LOAD: begin
                    state_q <= (mode_q == MODE_NONE) ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        if (cmd_op == OP_STOP) begin
                            state_q <= ST_IDLE;
                        end else begin
                            // Preempt or abort: re-latch and reload through LOAD.
                            state_q <= ST_LOAD;
                            base_q  <= cmd_base;
                            limit_q <= cmd_limit;
                            mode_q  <= (cmd_op == OP_ONESHOT) ? MODE_ONESHOT :
                                       (cmd_op == OP_RELOAD)  ? MODE_RELOAD  :
                                                                MODE_NONE;
                        end
                    end else if (tick && at_limit) begin
                        done_q <= 1'b1;
                        if (mode_q != MODE_RELOAD) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    loadable_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (cnt_load),
        .base_i  (base_q),
        .en_i    (cnt_en),
        .count_o (cnt_value)
    );

    assign count     = cnt_value;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = (state_q != ST_LOAD);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  import counter_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_base;
  logic [7:0] cmd_limit;
  logic       tick;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_base  (cmd_base),
    .cmd_limit (cmd_limit),
    .tick      (tick),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drives and samples happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] base, input logic [7:0] limit);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_limit = limit;
    step();
    cmd_valid = 1'b0;
  endtask

  logic [7:0] exp_cnt;
  logic       exp_done;
  int         pulses;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_STOP;
    cmd_base = 8'h00; cmd_limit = 8'h00; tick = 1'b0;
    #12;
    check_eq("rst_count", 32'(count), 32'h00);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    rst_n = 1'b1;
    step();

    // ---- one-shot 0x10 -> 0x14, tick held ----
    send_cmd(OP_ONESHOT, 8'h10, 8'h14);
    check_eq("os_load_state", 32'(dbg_state), 32'(ST_LOAD));
    check_eq("os_load_busy", 32'(busy), 32'd1);
    check_eq("os_load_ready", 32'(cmd_ready), 32'd0);
    step();
    check_eq("os_base", 32'(count), 32'h10);
    check_eq("os_run_state", 32'(dbg_state), 32'(ST_RUN));
    check_eq("os_run_ready", 32'(cmd_ready), 32'd1);
    tick = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("os_count", 32'(count), 32'h10 + 32'(i));
      check_eq("os_nodone", 32'(done), 32'd0);
    end
    step();
    check_eq("os_done", 32'(done), 32'd1);
    check_eq("os_end_busy", 32'(busy), 32'd0);
    check_eq("os_end_count", 32'(count), 32'h14);
    step();
    check_eq("os_done_drop", 32'(done), 32'd0);
    check_eq("os_hold_idle", 32'(count), 32'h14);
    tick = 1'b0;

    // ---- wrap with sparse ticks: FE -> 01 ----
    send_cmd(OP_ONESHOT, 8'hFE, 8'h01);
    step();
    check_eq("wr_base", 32'(count), 32'hFE);
    exp_cnt = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("wr_hold1", 32'(count), 32'(exp_cnt));
      step();
      check_eq("wr_hold2", 32'(count), 32'(exp_cnt));
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (k < 3) begin
        exp_cnt = exp_cnt + 8'd1;
        check_eq("wr_count", 32'(count), 32'(exp_cnt));
        check_eq("wr_nodone", 32'(done), 32'd0);
      end else begin
        check_eq("wr_done", 32'(done), 32'd1);
        check_eq("wr_end_count", 32'(count), 32'h01);
        check_eq("wr_end_busy", 32'(busy), 32'd0);
      end
    end
    step();
    check_eq("wr_done_drop", 32'(done), 32'd0);

    // ---- reload 0 -> 2, nine ticks ----
    send_cmd(OP_RELOAD, 8'h00, 8'h02);
    step();
    check_eq("rl_base", 32'(count), 32'h00);
    tick = 1'b1;
    exp_cnt = 8'h00;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (exp_cnt == 8'h02) begin
        exp_cnt = 8'h00; exp_done = 1'b1;
      end else begin
        exp_cnt = exp_cnt + 8'd1; exp_done = 1'b0;
      end
      step();
      check_eq("rl_count", 32'(count), 32'(exp_cnt));
      check_eq("rl_done", 32'(done), 32'(exp_done));
      check_eq("rl_busy", 32'(busy), 32'd1);
      if (done) pulses++;
    end
    check_eq("rl_pulses", 32'(pulses), 32'd3);
    tick = 1'b0;
    send_cmd(OP_STOP, 8'h00, 8'h00);
    check_eq("rl_stop_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rl_stop_count", 32'(count), 32'h00);
    check_eq("rl_stop_done", 32'(done), 32'd0);

    // ---- collision: STOP on the terminal tick ----
    send_cmd(OP_ONESHOT, 8'h20, 8'h22);
    step();
    tick = 1'b1;
    step();
    step();
    check_eq("co_at_limit", 32'(count), 32'h22);
    send_cmd(OP_STOP, 8'h00, 8'h00);
    tick = 1'b0;
    check_eq("co_nodone", 32'(done), 32'd0);
    check_eq("co_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("co_count", 32'(count), 32'h22);
    step();
    check_eq("co_nodone2", 32'(done), 32'd0);
    // base == limit: done on the first tick
    send_cmd(OP_ONESHOT, 8'h22, 8'h22);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("eq_done", 32'(done), 32'd1);
    check_eq("eq_count", 32'(count), 32'h22);
    check_eq("eq_state", 32'(dbg_state), 32'(ST_IDLE));

    // ---- START preempt and LOAD_ONLY abort in RUN ----
    send_cmd(OP_ONESHOT, 8'h50, 8'h60);
    step();
    tick = 1'b1;
    step();
    step();
    check_eq("pe_count", 32'(count), 32'h52);
    send_cmd(OP_RELOAD, 8'h70, 8'h71);
    check_eq("pe_noinc", 32'(count), 32'h52);
    check_eq("pe_state", 32'(dbg_state), 32'(ST_LOAD));
    step();
    check_eq("pe_base", 32'(count), 32'h70);
    send_cmd(OP_LOAD, 8'h11, 8'h00);
    check_eq("ab_noinc", 32'(count), 32'h70);
    step();
    check_eq("ab_count", 32'(count), 32'h11);
    check_eq("ab_state", 32'(dbg_state), 32'(ST_IDLE));
    tick = 1'b0;

    // ---- LOAD_ONLY from IDLE ----
    send_cmd(OP_LOAD, 8'hA5, 8'h00);
    check_eq("lo_ready", 32'(cmd_ready), 32'd0);
    check_eq("lo_busy", 32'(busy), 32'd1);
    step();
    check_eq("lo_count", 32'(count), 32'hA5);
    check_eq("lo_busy_end", 32'(busy), 32'd0);
    check_eq("lo_ready_end", 32'(cmd_ready), 32'd1);
    check_eq("lo_nodone", 32'(done), 32'd0);
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    check_eq("lo_ignore_tick", 32'(count), 32'hA5);
    check_eq("lo_nodone2", 32'(done), 32'd0);

    // ---- async reset mid-RUN at 0x37 ----
    send_cmd(OP_ONESHOT, 8'h30, 8'h40);
    step();
    tick = 1'b1;
    for (int i = 0; i < 7; i++) step();
    tick = 1'b0;
    check_eq("ar_pre_count", 32'(count), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_count", 32'(count), 32'h00);
    check_eq("ar_busy", 32'(busy), 32'd0);
    check_eq("ar_done", 32'(done), 32'd0);
    check_eq("ar_ready", 32'(cmd_ready), 32'd1);
    check_eq("ar_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    rst_n = 1'b1;
    send_cmd(OP_LOAD, 8'h5A, 8'h00);
    check_eq("ar_first_cmd", 32'(dbg_state), 32'(ST_LOAD));
    step();
    check_eq("ar_first_count", 32'(count), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
